// File: rtl/affine_pkg.sv
// Shared constants and types for the affine MAC execution unit.
// sat_n is only referenced when AFFINE_SAT_EN is defined.
package affine;

  localparam int unsigned N = 16;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    MUL  = 2'd1,
    MAC  = 2'd2,
    BFLY = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    FINAL = 2'd2
  } mac_state_t;

  // Clamp a sign-extended 2N+1 bit value into the signed N-bit range.
  function automatic logic signed [N-1:0] sat_n(input logic signed [2*N:0] x);
    logic signed [2*N:0] hi;
    logic signed [2*N:0] lo;
    hi = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    lo = {{(N+2){1'b1}}, {(N-1){1'b0}}};
    if (x > hi)      sat_n = hi[N-1:0];
    else if (x < lo) sat_n = lo[N-1:0];
    else             sat_n = x[N-1:0];
  endfunction

endpackage

// File: rtl/affine_mac_if.sv
// Register-file side bundle of the affine MAC: read operands in, write-back out.
// master = register file / requester, slave = affine_mac.
interface affine_mac_if import affine::*; ();

  logic                start_i;
  op_t                 op_i;
  logic [1:0]          dest_i;
  logic signed [N-1:0] rs_data_i;
  logic signed [N-1:0] rd_data_i;
  logic signed [N-1:0] acc1_i;
  logic signed [N-1:0] acc2_i;

  logic                busy_o;
  logic                done_o;
  logic                wr_en_o;
  logic                wdual_o;
  logic [1:0]          wd_addr_o;
  logic signed [N-1:0] wd_data_o;
  logic signed [N-1:0] acc2_o;

  modport master (
    output start_i, op_i, dest_i, rs_data_i, rd_data_i, acc1_i, acc2_i,
    input  busy_o, done_o, wr_en_o, wdual_o, wd_addr_o, wd_data_o, acc2_o
  );

  modport slave (
    input  start_i, op_i, dest_i, rs_data_i, rd_data_i, acc1_i, acc2_i,
    output busy_o, done_o, wr_en_o, wdual_o, wd_addr_o, wd_data_o, acc2_o
  );

endinterface

// File: rtl/affine_shift_mul.sv
// Radix-2 shift-add magnitude multiplier, one partial product per cycle.
// done_o is high during the cycle whose clock edge adds the last partial product.
module affine_shift_mul import affine::*; (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic                done_o,
  output logic                neg_o,
  output logic [2*N-1:0]      prod_o
);

  localparam int unsigned CNT_W = $clog2(N);

  logic [N-1:0]     mag_a_q;
  logic [N-1:0]     mag_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             neg_q;
  logic [2*N-1:0]   prod_q;
  logic [2*N-1:0]   addend;

  // The most negative input maps to 2**(N-1), which still fits unsigned N bits.
  function automatic logic [N-1:0] mag(input logic signed [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  assign addend = {{N{1'b0}}, mag_a_q} << cnt_q;
  assign done_o = run_q && (cnt_q == CNT_W'(N-1));
  assign neg_o  = neg_q;
  assign prod_o = prod_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else if (start_i) begin
      mag_a_q <= mag(a_i);
      mag_b_q <= mag(b_i);
      neg_q   <= a_i[N-1] ^ b_i[N-1];
      prod_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (mag_b_q[cnt_q]) prod_q <= prod_q + addend;
      if (done_o) run_q <= 1'b0;
      else        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/affine_mac.sv
// Iterative fixed-point MAC unit feeding the 4-entry register file write-back.
// Define AFFINE_SAT_EN for saturating reductions; default build wraps.
//
// state | meaning
// IDLE  | waiting for start_i (ignored while busy)
// MULT  | shift-add multiplier stepping, one bit per cycle
// FINAL | result formed from latched operands, registered on exit edge
module affine_mac import affine::*; #(
  parameter int unsigned FRAC = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  affine_mac_if.slave  bus
);

  mac_state_t          state_q, state_d;

  op_t                 op_q;
  logic [1:0]          dest_q;
  logic signed [N-1:0] a_q, b_q, acc1_q, acc2_in_q;

  logic                busy_q, done_q, wr_en_q, wdual_q;
  logic [1:0]          wd_addr_q;
  logic signed [N-1:0] wd_data_q, acc2_q;

  logic                accept, mul_start, mul_done, mul_neg, fin;
  logic [2*N-1:0]      mul_mag;

  logic signed [2*N-1:0] prod_s, prod_sh;
  logic signed [N-1:0]   p_n, res_wd, res_a2;
  logic signed [N:0]     sum_ab, sum_acc1, dif_acc2;
  logic                  res_dual;

  function automatic logic signed [N-1:0] reduce_n(input logic signed [2*N:0] x);
`ifdef AFFINE_SAT_EN
    return sat_n(x);
`else
    return x[N-1:0];
`endif
  endfunction

  assign accept = bus.start_i && !busy_q;

  affine_shift_mul u_mul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (mul_start),
    .a_i     (bus.rs_data_i),
    .b_i     (bus.rd_data_i),
    .done_o  (mul_done),
    .neg_o   (mul_neg),
    .prod_o  (mul_mag)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (bus.op_i == ADD) ? FINAL : MULT;
      MULT:    if (mul_done) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_start = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE:    mul_start = accept && (bus.op_i != ADD);
      FINAL:   fin = 1'b1;
      default: ;
    endcase
  end

  // Sign is applied only here; the multiplier works purely on magnitudes.
  always_comb begin
    prod_s   = mul_neg ? -$signed(mul_mag) : $signed(mul_mag);
    prod_sh  = prod_s >>> FRAC;
    p_n      = reduce_n({prod_sh[2*N-1], prod_sh});
    sum_ab   = {a_q[N-1], a_q} + {b_q[N-1], b_q};
    sum_acc1 = {acc1_q[N-1], acc1_q} + {p_n[N-1], p_n};
    dif_acc2 = {acc2_in_q[N-1], acc2_in_q} - {p_n[N-1], p_n};
    res_dual = (op_q == BFLY);
    res_a2   = reduce_n({{N{dif_acc2[N]}}, dif_acc2});
    case (op_q)
      ADD:     res_wd = reduce_n({{N{sum_ab[N]}}, sum_ab});
      MUL:     res_wd = p_n;
      default: res_wd = reduce_n({{N{sum_acc1[N]}}, sum_acc1});
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= ADD;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc1_q    <= '0;
      acc2_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wdual_q   <= 1'b0;
      wd_addr_q <= '0;
      wd_data_q <= '0;
      acc2_q    <= '0;
    end else begin
      done_q  <= fin;
      wr_en_q <= fin && (res_dual || (dest_q != 2'd0));
      // busy covers the done cycle so a start there is ignored.
      if (accept)      busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;
      if (accept) begin
        op_q      <= bus.op_i;
        dest_q    <= bus.dest_i;
        a_q       <= bus.rs_data_i;
        b_q       <= bus.rd_data_i;
        acc1_q    <= bus.acc1_i;
        acc2_in_q <= bus.acc2_i;
      end
      if (fin) begin
        wd_data_q <= res_wd;
        wd_addr_q <= dest_q;
        wdual_q   <= res_dual;
        if (res_dual) acc2_q <= res_a2;
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wdual_o   = wdual_q;
  assign bus.wd_addr_o = wd_addr_q;
  assign bus.wd_data_o = wd_data_q;
  assign bus.acc2_o    = acc2_q;

endmodule

// File: tb/tb_affine_mac.sv
// Scoreboard bench for affine_mac: expected results queued at start, compared at done_o.
`timescale 1ns/1ps
module tb_affine_mac;
  import affine::*;

  localparam int unsigned FRAC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  affine_mac_if bus ();

  affine_mac #(.FRAC(FRAC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] wd;
    logic [15:0] a2;
    logic        dual;
    logic        wren;
    logic [1:0]  addr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [15:0] o_wd, o_a2;
  logic        o_dual, o_wren;
  logic [1:0]  o_addr;
  int          o_lat;
  bit          o_to;

  function automatic logic [15:0] red(input longint v);
`ifdef AFFINE_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic exp_t model(input op_t op, input logic [1:0] dest,
                                 input logic [15:0] a, b, c1, c2);
    exp_t e;
    shortint sa, sbv, s1, s2, sp;
    longint pr;
    sa = a; sbv = b; s1 = c1; s2 = c2;
    pr = longint'(sa) * longint'(sbv);
    sp = red(pr >>> FRAC);
    e.a2 = 16'h0;
    case (op)
      ADD:     e.wd = red(longint'(sa) + longint'(sbv));
      MUL:     e.wd = sp;
      default: e.wd = red(longint'(s1) + longint'(sp));
    endcase
    if (op == BFLY) e.a2 = red(longint'(s2) - longint'(sp));
    e.dual = (op == BFLY);
    e.wren = e.dual || (dest != 2'd0);
    e.addr = dest;
    e.lat  = (op == ADD) ? 1 : 17;
    return e;
  endfunction

  task automatic start_op(input op_t op, input logic [1:0] dest,
                          input logic [15:0] a, b, c1, c2, input bit push);
    @(negedge clk);
    bus.op_i      = op;
    bus.dest_i    = dest;
    bus.rs_data_i = a;
    bus.rd_data_i = b;
    bus.acc1_i    = c1;
    bus.acc2_i    = c2;
    bus.start_i   = 1'b1;
    if (push) sb.push_back(model(op, dest, a, b, c1, c2));
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    bus.op_i      = op_t'($urandom_range(0, 3));
    bus.dest_i    = 2'($urandom);
    bus.rs_data_i = 16'($urandom);
    bus.rd_data_i = 16'($urandom);
    bus.acc1_i    = 16'($urandom);
    bus.acc2_i    = 16'($urandom);
  endtask

  task automatic wait_done();
    o_lat = 0;
    o_to  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      o_lat++;
      if (bus.done_o) begin
        o_to   = 1'b0;
        o_wd   = bus.wd_data_o;
        o_a2   = bus.acc2_o;
        o_dual = bus.wdual_o;
        o_wren = bus.wr_en_o;
        o_addr = bus.wd_addr_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.op_i = ADD; bus.dest_i = 2'd0;
    bus.rs_data_i = '0; bus.rd_data_i = '0; bus.acc1_i = '0; bus.acc2_i = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.wr_en_o, bus.wdual_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.busy_o, bus.done_o, bus.wr_en_o, bus.wdual_o});
    end
    checks++;
    if (bus.wd_addr_o !== 2'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.wd_addr_o); end
    checks++;
    if (bus.wd_data_o !== 16'h0) begin errors++; $display("FAIL reset_wd got %h want 0000", bus.wd_data_o); end
    checks++;
    if (bus.acc2_o !== 16'h0) begin errors++; $display("FAIL reset_acc2 got %h want 0000", bus.acc2_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    exp_t e;
    start_op(MUL, 2'd1, 16'h0200, 16'h0180, 16'h0, 16'h0, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to) begin errors++; $display("FAIL mul_timeout got no done want done"); end
    checks++;
    if (o_wd !== e.wd) begin errors++; $display("FAIL mul_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat) begin errors++; $display("FAIL mul_latency got %0d want %0d", o_lat, e.lat); end
    checks++;
    if ({o_wren, o_dual} !== {e.wren, e.dual}) begin errors++; $display("FAIL mul_strobes got %b want %b", {o_wren, o_dual}, {e.wren, e.dual}); end
    checks++;
    if (o_addr !== e.addr) begin errors++; $display("FAIL mul_addr got %h want %h", o_addr, e.addr); end
    checks++;
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mul_busy_done got %b want 1", bus.busy_o); end
    @(posedge clk); #1;
    checks++;
    if ({bus.busy_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL mul_after got %b want 00", {bus.busy_o, bus.done_o}); end
  endtask

  task automatic test_mac();
    exp_t e;
    start_op(MAC, 2'd2, 16'hFF00, 16'h0200, 16'h0100, 16'h1234, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL mac_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat) begin errors++; $display("FAIL mac_latency got %0d want %0d", o_lat, e.lat); end
    checks++;
    if ({o_wren, o_dual} !== {e.wren, e.dual}) begin errors++; $display("FAIL mac_strobes got %b want %b", {o_wren, o_dual}, {e.wren, e.dual}); end
    @(posedge clk); #1;
  endtask

  task automatic test_bfly();
    exp_t e;
    start_op(BFLY, 2'd0, 16'h0200, 16'h0100, 16'h7F00, 16'h0000, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL bfly_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_a2 !== e.a2) begin errors++; $display("FAIL bfly_acc2 got %h want %h", o_a2, e.a2); end
    checks++;
    if ({o_wren, o_dual} !== {e.wren, e.dual}) begin errors++; $display("FAIL bfly_strobes got %b want %b", {o_wren, o_dual}, {e.wren, e.dual}); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_ops();
    exp_t e;
    logic [15:0] a, b, c1, c2;
    op_t op;
    logic [1:0] dest;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin op = MUL; dest = 2'd0; a = 16'hFFFF; b = 16'h0080; c1 = 16'h0; c2 = 16'h0; end
      else if (i == 1) begin op = MUL; dest = 2'd3; a = 16'h8000; b = 16'h8000; c1 = 16'h0; c2 = 16'h0; end
      else begin
        op = op_t'($urandom_range(0, 3)); dest = 2'($urandom);
        a = 16'($urandom); b = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom);
      end
      start_op(op, dest, a, b, c1, c2, 1'b1);
      wait_done();
      e = sb.pop_front();
      checks++;
      if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL rand%0d_wd op %0d got %h want %h", i, op, o_wd, e.wd); end
      checks++;
      if (o_lat != e.lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, o_lat, e.lat); end
      checks++;
      if ({o_wren, o_dual, o_addr} !== {e.wren, e.dual, e.addr}) begin
        errors++; $display("FAIL rand%0d_strobes got %b want %b", i, {o_wren, o_dual, o_addr}, {e.wren, e.dual, e.addr});
      end
      if (e.dual) begin
        checks++;
        if (o_a2 !== e.a2) begin errors++; $display("FAIL rand%0d_acc2 got %h want %h", i, o_a2, e.a2); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    start_op(ADD, 2'd3, 16'h0005, 16'hFFFE, 16'h0, 16'h0, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL add_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat) begin errors++; $display("FAIL add_latency got %0d want %0d", o_lat, e.lat); end
    @(posedge clk); #1;
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", bus.busy_o); end
    start_op(ADD, 2'd0, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL b2b_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", o_lat, e.lat); end
    checks++;
    if (o_wren !== e.wren) begin errors++; $display("FAIL b2b_wren got %b want %b", o_wren, e.wren); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int ndone;
    bit got;
    ndone = 0; got = 1'b0; o_lat = 0; o_wd = '0; o_addr = '0;
    start_op(MUL, 2'd1, 16'h0200, 16'h0180, 16'h0, 16'h0, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        bus.op_i = ADD; bus.dest_i = 2'd2;
        bus.rs_data_i = 16'h1111; bus.rd_data_i = 16'h2222;
        bus.start_i = 1'b1;
      end
      if (i == 6) bus.start_i = 1'b0;
      if (bus.done_o) begin
        ndone++;
        if (!got) begin got = 1'b1; o_lat = i; o_wd = bus.wd_data_o; o_addr = bus.wd_addr_o; end
      end
    end
    e = sb.pop_front();
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    checks++;
    if (o_wd !== e.wd) begin errors++; $display("FAIL ignore_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat || o_addr !== e.addr) begin
      errors++; $display("FAIL ignore_lat_addr got %0d/%h want %0d/%h", o_lat, o_addr, e.lat, e.addr);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int ndone;
    start_op(MAC, 2'd2, 16'hFF00, 16'h0200, 16'h0100, 16'h0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy_o, bus.done_o, bus.wr_en_o, bus.wdual_o} !== 4'b0000) begin
      errors++; $display("FAIL midrst_ctrl got %b want 0000", {bus.busy_o, bus.done_o, bus.wr_en_o, bus.wdual_o});
    end
    checks++;
    if ({bus.wd_data_o, bus.acc2_o, bus.wd_addr_o} !== 34'h0) begin
      errors++; $display("FAIL midrst_data got %h/%h/%h want 0", bus.wd_data_o, bus.acc2_o, bus.wd_addr_o);
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.wr_en_o) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    start_op(MUL, 2'd3, 16'h0300, 16'hFE00, 16'h0, 16'h0, 1'b1);
    wait_done();
    e = sb.pop_front();
    checks++;
    if (o_to || o_wd !== e.wd) begin errors++; $display("FAIL midrst_mul_wd got %h want %h", o_wd, e.wd); end
    checks++;
    if (o_lat != e.lat || o_addr !== e.addr || o_wren !== e.wren) begin
      errors++; $display("FAIL midrst_mul_meta got %0d/%h/%b want %0d/%h/%b", o_lat, o_addr, o_wren, e.lat, e.addr, e.wren);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mac();
    test_bfly();
    test_random_ops();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
